mac_seq: RTL and testbench

MAC_SEQ -- requirements
Module: mac_seq

---
 rtl/mac_seq.sv | 162 ++++++++++++++++
 tb/tb_mac_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// MAC job sequencer: takes a job command, streams operand pairs into an external
// MAC as load/accumulate (and optional saturate) steps, then returns its result.
module mac_seq #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_sat,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic [2:0]       mac_instruction,
    output logic [15:0]      mac_multiplier,
    output logic [15:0]      mac_multiplicand,
    output logic             mac_stall,
    input  logic [31:0]      mac_result,
    input  logic [7:0]       mac_protect,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [7:0]       res_guard,
    output logic             busy
);

    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned DRN_W = 2;
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(2);

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_LD  = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_SAT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_SAT   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               mode_q;
    logic               sat_q;
    logic               first_q;
    logic [CNT_W-1:0]   rem_q;
    logic [DRN_W-1:0]   drain_q;

    logic               cmd_hs;
    logic               op_hs;
    logic               last_pair;
    logic               drain_end;
    logic               res_hs;

    assign cmd_hs    = (state_q == S_IDLE) && cmd_valid;
    assign op_hs     = (state_q == S_RUN) && op_valid;
    assign last_pair = (rem_q == CNT_W'(1));
    assign drain_end = (state_q == S_DRAIN) && (drain_q == DRAIN_LAST);
    assign res_hs    = (state_q == S_DONE) && res_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_RUN;
            S_RUN:   if (op_valid && last_pair) state_d = sat_q ? S_SAT : S_DRAIN;
            S_SAT:   state_d = S_DRAIN;
            S_DRAIN: if (drain_q == DRAIN_LAST) state_d = S_DONE;
            S_DONE:  if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags and MAC drive; operands only pass through while running
    always_comb begin
        cmd_ready        = 1'b0;
        op_ready         = 1'b0;
        busy             = 1'b1;
        mac_stall        = 1'b0;
        mac_instruction  = {mode_q, OP_CLR};
        mac_multiplier   = 16'h0000;
        mac_multiplicand = 16'h0000;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_RUN: begin
                op_ready         = 1'b1;
                mac_stall        = !op_valid;
                mac_instruction  = {mode_q, first_q ? OP_LD : OP_ACC};
                mac_multiplier   = op_a;
                mac_multiplicand = op_b;
            end
            S_SAT: begin
                mac_instruction = {mode_q, OP_SAT};
            end
            default: begin
            end
        endcase
    end

    // Job context: a zero length field stands for the full 2^LEN_W pairs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= 1'b0;
            sat_q   <= 1'b0;
            first_q <= 1'b0;
            rem_q   <= '0;
        end else if (cmd_hs) begin
            mode_q  <= cmd_mode;
            sat_q   <= cmd_sat;
            first_q <= 1'b1;
            rem_q   <= (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : CNT_W'(cmd_len);
        end else if (op_hs) begin
            first_q <= 1'b0;
            rem_q   <= rem_q - CNT_W'(1);
        end
    end

    // Drain timer covers the MAC pipeline latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_q <= '0;
        end else if (state_q == S_DRAIN) begin
            drain_q <= drain_q + DRN_W'(1);
        end else begin
            drain_q <= '0;
        end
    end

    // Result capture and hold until acknowledged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_guard <= '0;
        end else if (drain_end) begin
            res_valid <= 1'b1;
            res_data  <= mac_result;
            res_guard <= mac_protect;
        end else if (res_hs) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: behavioural MAC in the loop, directed and random jobs,
// scoreboard of expected results popped by an independent monitor.
module tb_mac_seq;

    localparam int unsigned LEN_W = 8;

    logic             clk;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_sat;
    logic             op_valid;
    logic             op_ready;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic [2:0]       mac_instruction;
    logic [15:0]      mac_multiplier;
    logic [15:0]      mac_multiplicand;
    logic             mac_stall;
    logic [31:0]      mac_result;
    logic [7:0]       mac_protect;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [7:0]       res_guard;
    logic             busy;

    mac_seq #(.LEN_W(LEN_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_mode         (cmd_mode),
        .cmd_len          (cmd_len),
        .cmd_sat          (cmd_sat),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .op_a             (op_a),
        .op_b             (op_b),
        .mac_instruction  (mac_instruction),
        .mac_multiplier   (mac_multiplier),
        .mac_multiplicand (mac_multiplicand),
        .mac_stall        (mac_stall),
        .mac_result       (mac_result),
        .mac_protect      (mac_protect),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_guard        (res_guard),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint v, input int bits);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (bits - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    // Behavioural downstream MAC: 40-bit accumulator (or two 20-bit lanes), 3-edge latency
    function automatic logic [39:0] mac_exec(input logic [39:0] acc_in, input logic [2:0] ins,
                                             input logic [15:0] a, input logic [15:0] b);
        longint v, p, h, l, ph, pl;
        logic [63:0] r, rh, rl;
        if (!ins[2]) begin
            v = longint'($signed(acc_in));
            p = longint'($signed(a)) * longint'($signed(b));
            case (ins[1:0])
                2'b00:   v = 0;
                2'b01:   v = p;
                2'b10:   v = v + p;
                default: v = clamp(v, 32);
            endcase
            r = v;
            return r[39:0];
        end
        h  = longint'($signed(acc_in[39:20]));
        l  = longint'($signed(acc_in[19:0]));
        ph = longint'($signed(a[15:8])) * longint'($signed(b[15:8]));
        pl = longint'($signed(a[7:0])) * longint'($signed(b[7:0]));
        case (ins[1:0])
            2'b00:   begin h = 0; l = 0; end
            2'b01:   begin h = ph; l = pl; end
            2'b10:   begin h = h + ph; l = l + pl; end
            default: begin h = clamp(h, 16); l = clamp(l, 16); end
        endcase
        rh = h;
        rl = l;
        return {rh[19:0], rl[19:0]};
    endfunction

    logic [2:0]  s1_ins, s2_ins;
    logic [15:0] s1_a, s1_b, s2_a, s2_b;
    logic [39:0] acc;
    logic        acc_mode;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_ins <= 3'd0; s1_a <= 16'd0; s1_b <= 16'd0;
            s2_ins <= 3'd0; s2_a <= 16'd0; s2_b <= 16'd0;
            acc <= 40'd0; acc_mode <= 1'b0;
        end else if (!mac_stall) begin
            s1_ins <= mac_instruction; s1_a <= mac_multiplier; s1_b <= mac_multiplicand;
            s2_ins <= s1_ins; s2_a <= s1_a; s2_b <= s1_b;
            acc <= mac_exec(acc, s2_ins, s2_a, s2_b);
            acc_mode <= s2_ins[2];
        end
    end

    assign mac_result  = acc_mode ? {acc[35:20], acc[15:0]} : acc[31:0];
    assign mac_protect = acc_mode ? {acc[39:36], acc[19:16]} : acc[39:32];

    // Scoreboard
    typedef struct {
        logic [31:0] data;
        logic [7:0]  guard;
        int          lat;
        int          stalls;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          qg[$];

    // Reference: plain sums of signed products over the job's pairs
    function automatic void ref_calc(input bit mode, input bit sat,
                                     output logic [31:0] d, output logic [7:0] g);
        longint s, hi, lo;
        logic [15:0] a, b;
        logic [63:0] sv, hv, lv;
        s = 0; hi = 0; lo = 0;
        for (int i = 0; i < qa.size(); i++) begin
            a = qa[i];
            b = qb[i];
            s  += longint'($signed(a)) * longint'($signed(b));
            hi += longint'($signed(a[15:8])) * longint'($signed(b[15:8]));
            lo += longint'($signed(a[7:0])) * longint'($signed(b[7:0]));
        end
        if (sat) begin
            s  = clamp(s, 32);
            hi = clamp(hi, 16);
            lo = clamp(lo, 16);
        end
        sv = s; hv = hi; lv = lo;
        if (!mode) begin
            d = sv[31:0];
            g = sv[39:32];
        end else begin
            d = {hv[15:0], lv[15:0]};
            g = {hv[19:16], lv[19:16]};
        end
    endfunction

    // Monitor: pops on each new result, then checks hold behaviour while it waits
    int   mon_cyc = 0;
    int   mon_last_hs = 0;
    int   mon_stalls = 0;
    bit   mon_seen = 1'b0;
    exp_t mon_cur;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_stalls = 0;
                mon_seen   = 1'b0;
            end else begin
                mon_cyc++;
                if (op_valid && op_ready) mon_last_hs = mon_cyc;
                if (mac_stall) mon_stalls++;
                if (res_valid && !mon_seen) begin
                    mon_seen = 1'b1;
                    if (sb.size() == 0) begin
                        check("unexpected_result", 64'(sb.size()), 64'd1);
                    end else begin
                        mon_cur = sb.pop_front();
                        check("res_data", res_data, mon_cur.data);
                        check("res_guard", res_guard, mon_cur.guard);
                        check("result_latency", 64'(mon_cyc - mon_last_hs), 64'(mon_cur.lat));
                        check("stall_cycles", 64'(mon_stalls), 64'(mon_cur.stalls));
                    end
                    mon_stalls = 0;
                end else if (res_valid) begin
                    check("hold_data", {res_guard, res_data}, {mon_cur.guard, mon_cur.data});
                end
                if (res_valid) check("done_flags", {cmd_ready, busy, mac_stall}, 3'b010);
                if (!res_valid) mon_seen = 1'b0;
            end
        end
    end

    task automatic add_pair(input logic [15:0] a, input logic [15:0] b, input int gap);
        qa.push_back(a);
        qb.push_back(b);
        qg.push_back(gap);
    endtask

    task automatic clear_pairs();
        qa.delete();
        qb.delete();
        qg.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_res"}, {res_valid, res_data, res_guard, busy}, 64'd0);
        check({tag, "_mac"}, {mac_stall, mac_instruction, mac_multiplier, mac_multiplicand}, 64'd0);
        check({tag, "_rdy"}, {cmd_ready, op_ready}, 2'b10);
    endtask

    task automatic issue_cmd(input bit mode, input int len_field, input bit sat);
        int t;
        cmd_mode  = mode;
        cmd_len   = LEN_W'(len_field);
        cmd_sat   = sat;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed_pairs(input int count);
        for (int i = 0; i < count; i++) begin
            op_valid  = 1'b1;
            op_a      = qa[i];
            op_b      = qb[i];
            cmd_valid = 1'($urandom % 2);
            cmd_len   = LEN_W'($urandom);
            cmd_mode  = 1'($urandom % 2);
            @(posedge clk); #1;
            op_valid = 1'b0;
            for (int g = 0; g < qg[i]; g++) begin
                op_a = 16'($urandom);
                op_b = 16'($urandom);
                @(posedge clk); #1;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic run_job(input bit mode, input int len_field, input bit sat, input bit use_lit,
                           input logic [31:0] lit_d, input logic [7:0] lit_g, input int hold);
        exp_t e;
        int   t;
        if (use_lit) begin
            e.data  = lit_d;
            e.guard = lit_g;
        end else begin
            ref_calc(mode, sat, e.data, e.guard);
        end
        e.lat    = sat ? 5 : 4;
        e.stalls = 0;
        for (int i = 0; i < qg.size() - 1; i++) e.stalls += qg[i];
        sb.push_back(e);

        issue_cmd(mode, len_field, sat);
        feed_pairs(qa.size());

        t = 0;
        while (!res_valid && t < 100) begin
            op_valid = 1'($urandom % 2);
            op_a     = 16'($urandom);
            @(posedge clk); #1;
            t++;
        end
        op_valid = 1'b0;
        if (!res_valid) begin
            check("result_timeout", res_valid, 1'b1);
        end else begin
            res_ready = 1'b0;
            repeat (hold) begin
                @(posedge clk); #1;
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            check("idle_after_ack", {res_valid, cmd_ready, busy}, 3'b010);
        end
    endtask

    task automatic load_req030(input int gap_first);
        clear_pairs();
        add_pair(16'd2, 16'd3, gap_first);
        add_pair(16'd4, 16'd5, 0);
        add_pair(16'hFFFF, 16'd6, 0);
    endtask

    initial begin
        int n;
        bit m;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 1'b0;
        cmd_len   = '0;
        cmd_sat   = 1'b0;
        op_valid  = 1'b0;
        op_a      = 16'd0;
        op_b      = 16'd0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        load_req030(0);
        run_job(1'b0, 3, 1'b0, 1'b1, 32'h0000_0014, 8'h00, 0);

        clear_pairs();
        add_pair(16'h0203, 16'h0405, 0);
        run_job(1'b1, 1, 1'b0, 1'b1, 32'h0008_000F, 8'h00, 1);

        clear_pairs();
        add_pair(16'h8000, 16'h8000, 0);
        add_pair(16'h8000, 16'h8000, 0);
        run_job(1'b0, 2, 1'b0, 1'b1, 32'h8000_0000, 8'h00, 0);
        run_job(1'b0, 2, 1'b1, 1'b1, 32'h7FFF_FFFF, 8'h00, 0);

        load_req030(2);
        run_job(1'b0, 3, 1'b0, 1'b1, 32'h0000_0014, 8'h00, 0);

        load_req030(0);
        run_job(1'b0, 3, 1'b0, 1'b1, 32'h0000_0014, 8'h00, 5);

        // Reset in the middle of a len-4 job: nothing may come out of it
        clear_pairs();
        for (int i = 0; i < 4; i++) add_pair(16'($urandom), 16'($urandom), 0);
        issue_cmd(1'b1, 4, 1'b1);
        feed_pairs(2);
        op_valid = 1'b1;
        reset_n  = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("after_release");
        load_req030(0);
        run_job(1'b0, 3, 1'b0, 1'b1, 32'h0000_0014, 8'h00, 0);

        for (int j = 0; j < 30; j++) begin
            clear_pairs();
            n = $urandom_range(1, 12);
            m = 1'($urandom % 2);
            for (int i = 0; i < n; i++)
                add_pair(16'($urandom), 16'($urandom),
                         (i == n - 1 || ($urandom % 4) != 0) ? 0 : $urandom_range(1, 3));
            run_job(m, n, 1'($urandom % 2), 1'b0, 32'd0, 8'd0, $urandom_range(0, 3));
        end

        // Zero length field means the full 2^LEN_W pairs
        clear_pairs();
        for (int i = 0; i < (1 << LEN_W); i++) add_pair(16'($urandom), 16'($urandom), 0);
        run_job(1'b0, 0, 1'b0, 1'b0, 32'd0, 8'd0, 0);

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
